// File: rtl/date_counter_pkg.sv
// Shared definitions for the calendar date counter: field widths, field select
// codes and calendar limits.
package date_counter_pkg;

   localparam int DAY_W   = 5;
   localparam int MONTH_W = 4;
   localparam int YEAR_W  = 7;
   localparam int DATA_W  = 7;

   localparam logic [MONTH_W-1:0] MONTH_MAX = 4'd12;
   localparam logic [YEAR_W-1:0]  YEAR_MAX  = 7'd99;
   localparam logic [MONTH_W-1:0] MONTH_FEB = 4'd2;

   typedef enum logic [1:0] {
      SEL_DAY   = 2'd0,
      SEL_MONTH = 2'd1,
      SEL_YEAR  = 2'd2,
      SEL_RSVD  = 2'd3
   } sel_e;

endpackage

// File: rtl/date_counter_day_of_month.sv
// Month length lookup (28/30/31) with optional February leap-year adjustment.
// Build option: define LEAP_YEAR_EN for 29-day February when year[1:0]==0.
module date_counter_day_of_month
   import date_counter_pkg::*;
(
   input  logic [MONTH_W-1:0] month,
   input  logic [YEAR_W-1:0]  year,
   output logic [DAY_W-1:0]   len
);

   logic leap;
   logic unused_year_bits;

   // Only the low bits matter for the 2000-2099 leap rule.
   assign unused_year_bits = ^year;

`ifdef LEAP_YEAR_EN
   assign leap = (year[1:0] == 2'b00);
`else
   assign leap = 1'b0;
`endif

   always_comb begin
      case (month)
         MONTH_FEB:                  len = leap ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11:    len = 5'd30;
         default:                    len = 5'd31;
      endcase
   end

endmodule

// File: rtl/date_counter.sv
// Calendar date register advanced by day_tick, with field-wise setting.
// Build option: LEAP_YEAR_EN enables the February leap-year rule.
module date_counter
   import date_counter_pkg::*;
#(
   parameter int unsigned RESET_YEAR  = 24,
   parameter int unsigned RESET_MONTH = 1,
   parameter int unsigned RESET_DAY   = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               day_tick,
   input  logic               set_valid,
   input  logic [1:0]         set_sel,
   input  logic [DATA_W-1:0]  set_data,
   output logic [DAY_W-1:0]   day,
   output logic [MONTH_W-1:0] month,
   output logic [YEAR_W-1:0]  year,
   output logic               new_month,
   output logic               new_year,
   output logic               set_err
);

   sel_e                sel;
   logic [DAY_W-1:0]    cur_len;
   logic [DAY_W-1:0]    cand_len;
   logic [MONTH_W-1:0]  cand_month;
   logic [YEAR_W-1:0]   cand_year;
   logic                set_ok;
   logic                pending;

   logic [DAY_W-1:0]    day_d;
   logic [MONTH_W-1:0]  month_d;
   logic [YEAR_W-1:0]   year_d;
   logic                pending_d;
   logic                new_month_d;
   logic                new_year_d;
   logic                set_err_d;

   assign sel = sel_e'(set_sel);

   // Length of the month as it stands now, and as it would be after a
   // month/year set (used to clamp the day).
   date_counter_day_of_month u_len_cur (
      .month (month),
      .year  (year),
      .len   (cur_len)
   );

   date_counter_day_of_month u_len_cand (
      .month (cand_month),
      .year  (cand_year),
      .len   (cand_len)
   );

   // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      cand_month = month;
      cand_year  = year;
      if (sel == SEL_MONTH) cand_month = set_data[MONTH_W-1:0];
      if (sel == SEL_YEAR)  cand_year  = set_data;
   end

   always_comb begin
      set_ok = 1'b0;
      case (sel)
         SEL_DAY:   set_ok = (set_data != '0) && (set_data <= DATA_W'(cur_len));
         SEL_MONTH: set_ok = (set_data != '0) && (set_data <= DATA_W'(MONTH_MAX));
         SEL_YEAR:  set_ok = (set_data <= DATA_W'(YEAR_MAX));
         default:   set_ok = 1'b0;
      endcase
   end

   // A set always wins its cycle; a tick seen meanwhile waits in pending and
   // is applied on the first cycle without set_valid.
   always_comb begin
      day_d       = day;
      month_d     = month;
      year_d      = year;
      pending_d   = pending;
      new_month_d = 1'b0;
      new_year_d  = 1'b0;
      set_err_d   = 1'b0;
      if (set_valid) begin
         pending_d = pending | day_tick;
         if (!set_ok) begin
            set_err_d = 1'b1;
         end else if (sel == SEL_DAY) begin
            day_d = set_data[DAY_W-1:0];
         end else begin
            month_d = cand_month;
            year_d  = cand_year;
            if (day > cand_len) day_d = cand_len;
         end
      end else if (day_tick || pending) begin
         pending_d = 1'b0;
         if (day < cur_len) begin
            day_d = day + DAY_W'(1);
         end else begin
            day_d       = DAY_W'(1);
            new_month_d = 1'b1;
            if (month == MONTH_MAX) begin
               month_d    = MONTH_W'(1);
               new_year_d = 1'b1;
               year_d     = (year == YEAR_MAX) ? '0 : year + YEAR_W'(1);
            end else begin
               month_d = month + MONTH_W'(1);
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!rst_n) day <= DAY_W'(RESET_DAY);
      else        day <= day_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) month <= MONTH_W'(RESET_MONTH);
      else        month <= month_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) year <= YEAR_W'(RESET_YEAR);
      else        year <= year_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) pending <= 1'b0;
      else        pending <= pending_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         new_month <= 1'b0;
         new_year  <= 1'b0;
         set_err   <= 1'b0;
      end else begin
         new_month <= new_month_d;
         new_year  <= new_year_d;
         set_err   <= set_err_d;
      end
   end

endmodule
